axil_uart_wr_slave: RTL and testbench

AXIL_UART_WR_SLAVE -- requirements
Module: axil_uart_wr_slave

---
 rtl/axil_uart_wr_slave.sv | 189 ++++++++++++++++++
 tb/tb_axil_uart_wr_slave.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_uart_wr_slave.sv
// AXI4-Lite write-only slave feeding a UART TX byte FIFO, plus baud divisor and TX enable registers.
// Latency: AW/W captured on their handshake edge, write committed (bvalid=1) on the next edge with both held.
// Backpressure: one write outstanding; awready/wready stay low while a phase is held or bvalid is pending.
// Build option: define AXIL_WR_SLVERR_EN to report SLVERR for unmapped writes and pushes dropped on a full FIFO.
module axil_uart_wr_slave #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [31:0]                   s_axi_wdata,
  input  logic [3:0]                    s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic [15:0]                   baud_div,
  output logic                          tx_en,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  // Register map index taken from awaddr[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_BAUD   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  logic             rdy_q, rdy_d;
  logic             aw_held_q, aw_held_d;
  logic [1:0]       awaddr_q, awaddr_d;
  logic             w_held_q, w_held_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [1:0]       wstrb_q, wstrb_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic [15:0]      baud_div_q, baud_div_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  logic aw_hs, w_hs, commit, push, pop, slverr;

  // Address bits outside the decode and data/strobe lanes no register uses
  logic unused_bits;
`ifdef AXIL_WR_SLVERR_EN
  assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_wdata[31:16], s_axi_wstrb[3:2]};
`else
  assign unused_bits = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_wdata[31:16], s_axi_wstrb[3:2], slverr};
`endif

  // rdy_q keeps both ready outputs low during reset and the edge that releases it
  assign s_axi_awready = rdy_q && !aw_held_q && !bvalid_q;
  assign s_axi_wready  = rdy_q && !w_held_q && !bvalid_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign baud_div      = baud_div_q;
  assign tx_en         = tx_en_q;
  assign tx_valid      = (level_q != '0);
  assign tx_data       = mem_q[rd_ptr_q];
  assign fifo_level    = level_q;

  assign aw_hs  = s_axi_awvalid && s_axi_awready;
  assign w_hs   = s_axi_wvalid && s_axi_wready;
  assign commit = aw_held_q && w_held_q;
  assign pop    = tx_valid && tx_ready;

  // Next-state: phase capture, write commit / response, FIFO push and pop
  always_comb begin
    rdy_d      = 1'b1;
    aw_held_d  = aw_held_q;
    awaddr_d   = awaddr_q;
    w_held_d   = w_held_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    baud_div_d = baud_div_q;
    tx_en_d    = tx_en_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    level_d    = level_q;
    push       = 1'b0;
    slverr     = 1'b0;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      awaddr_d  = s_axi_awaddr[3:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      wdata_d  = s_axi_wdata[15:0];
      wstrb_d  = s_axi_wstrb[1:0];
    end
    if (bvalid_q && s_axi_bready) begin
      bvalid_d = 1'b0;
    end

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      case (awaddr_q)
        REG_TXDATA: begin
          // Fullness is judged on the pre-pop level, so a same-cycle pop cannot make room
          if (wstrb_q[0]) begin
            if (level_q == FULL_LVL) slverr = 1'b1;
            else                     push   = 1'b1;
          end
        end
        REG_BAUD: begin
          if (wstrb_q[0]) baud_div_d[7:0]  = wdata_q[7:0];
          if (wstrb_q[1]) baud_div_d[15:8] = wdata_q[15:8];
        end
        REG_CTRL: begin
          if (wstrb_q[0]) tx_en_d = wdata_q[0];
        end
        default: slverr = 1'b1;
      endcase
`ifdef AXIL_WR_SLVERR_EN
      bresp_d = slverr ? 2'b10 : 2'b00;
`else
      bresp_d = 2'b00;
`endif
    end

    if (push) begin
      mem_d[wr_ptr_q] = wdata_q[7:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // State registers; reset discards any held phase and pending response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q      <= 1'b0;
      aw_held_q  <= 1'b0;
      awaddr_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      baud_div_q <= DIV_RESET;
      tx_en_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      rdy_q      <= rdy_d;
      aw_held_q  <= aw_held_d;
      awaddr_q   <= awaddr_d;
      w_held_q   <= w_held_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      baud_div_q <= baud_div_d;
      tx_en_q    <= tx_en_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
    end
  end

endmodule

// File: tb/tb_axil_uart_wr_slave.sv
// Randomized bench for axil_uart_wr_slave against a queue-based register/FIFO model.
// Honours AXIL_WR_SLVERR_EN the same way as the design build.
module tb_axil_uart_wr_slave;

  localparam int          DEPTH = 8;
  localparam logic [15:0] DIVR  = 16'd868;

  logic        clk, rst;
  logic [31:0] s_axi_awaddr, s_axi_wdata;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [3:0]  s_axi_wstrb;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid, s_axi_bready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [15:0] baud_div;
  logic        tx_en;
  logic [3:0]  fifo_level;

  axil_uart_wr_slave #(.FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .baud_div(baud_div), .tx_en(tx_en), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef AXIL_WR_SLVERR_EN
  localparam bit SLVERR_ON = 1'b1;
`else
  localparam bit SLVERR_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: register values and FIFO contents
  logic [7:0]  m_q[$];
  logic [15:0] m_baud;
  logic        m_txen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_baud = DIVR;
    m_txen = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_baud"},  32'(baud_div), 32'(m_baud));
    chk({tag, "_txen"},  32'(tx_en), 32'(m_txen));
    chk({tag, "_level"}, 32'(fifo_level), 32'(m_q.size()));
    chk({tag, "_tvld"},  32'(tx_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) chk({tag, "_tdata"}, 32'(tx_data), 32'(m_q[0]));
  endtask

  // Pulse reset mid-cycle and verify the held reset values and the release sequence
  task automatic do_reset();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; tx_ready = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_awready", 32'(s_axi_awready), 0);
    chk("rst_wready",  32'(s_axi_wready), 0);
    chk("rst_bvalid",  32'(s_axi_bvalid), 0);
    chk("rst_bresp",   32'(s_axi_bresp), 0);
    chk("rst_tvalid",  32'(tx_valid), 0);
    chk("rst_level",   32'(fifo_level), 0);
    chk("rst_tdata",   32'(tx_data), 0);
    chk("rst_baud",    32'(baud_div), 32'(DIVR));
    chk("rst_txen",    32'(tx_en), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rel_awready0", 32'(s_axi_awready), 0);
    tick();
    chk("rel_awready1", 32'(s_axi_awready), 1);
    chk("rel_wready1",  32'(s_axi_wready), 1);
  endtask

  // order: 0 same cycle, 1 AW leads W by gap, 2 W leads AW by gap
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int order, input int gap, input int bhold, input bit pop_at_commit);
    int aw_start, w_start, cyc;
    bit aw_done, w_done, aw_hs, w_hs, full, err;
    logic [1:0] sel;
    logic [1:0] exp_resp;
    aw_start = (order == 2) ? gap : 0;
    w_start  = (order == 1) ? gap : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    while (!(aw_done && w_done)) begin
      if (cyc > 60) begin
        chk("hs_timeout", 0, 1);
        break;
      end
      s_axi_awvalid = (cyc >= aw_start) && !aw_done;
      s_axi_wvalid  = (cyc >= w_start) && !w_done;
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;

    // Model: fullness judged before any pop in the commit cycle
    full = (m_q.size() == DEPTH);
    if (pop_at_commit) begin
      if (m_q.size() != 0) chk("pc_head", 32'(tx_data), 32'(m_q[0]));
      tx_ready = 1'b1;
    end
    tick();
    tx_ready = 1'b0;
    if (pop_at_commit && m_q.size() != 0) void'(m_q.pop_front());
    sel = addr[3:2];
    err = 0;
    case (sel)
      2'd0: if (strb[0]) begin
              if (full) err = 1;
              else m_q.push_back(data[7:0]);
            end
      2'd1: begin
              if (strb[0]) m_baud[7:0]  = data[7:0];
              if (strb[1]) m_baud[15:8] = data[15:8];
            end
      2'd2: if (strb[0]) m_txen = data[0];
      default: err = 1;
    endcase
    exp_resp = (SLVERR_ON && err) ? 2'b10 : 2'b00;

    chk("b_valid",  32'(s_axi_bvalid), 1);
    chk("b_resp",   32'(s_axi_bresp), 32'(exp_resp));
    chk("b_awrdy",  32'(s_axi_awready), 0);
    chk("b_wrdy",   32'(s_axi_wready), 0);
    for (int i = 0; i < bhold; i++) begin
      tick();
      chk("hold_bvalid", 32'(s_axi_bvalid), 1);
      chk("hold_bresp",  32'(s_axi_bresp), 32'(exp_resp));
      chk("hold_awrdy",  32'(s_axi_awready), 0);
    end
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    chk("b_done",     32'(s_axi_bvalid), 0);
    chk("b_awrdy_re", 32'(s_axi_awready), 1);
    chk_state("wr");
  endtask

  task automatic do_pops(input int n);
    for (int i = 0; i < n; i++) begin
      if (m_q.size() != 0) chk("pop_data", 32'(tx_data), 32'(m_q[0]));
      tx_ready = 1'b1;
      tick();
      if (m_q.size() != 0) void'(m_q.pop_front());
    end
    tx_ready = 1'b0;
    chk_state("pop");
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0]  sel;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_bready = 0; tx_ready = 0;
    rst = 1'b0;
    model_reset();
    #2;
    do_reset();

    // AW leads W by two cycles, TXDATA 0x41
    do_write(32'h0, 32'h41, 4'hF, 1, 2, 0, 0);
    chk("d1_tdata", 32'(tx_data), 32'h41);
    chk("d1_level", 32'(fifo_level), 1);
    // W leads AW, BAUD low byte only
    do_write(32'h4, 32'h1234, 4'h1, 2, 2, 0, 0);
    chk("d2_baud", 32'(baud_div), 32'h0334);
    do_pops(2);

    // Fill past capacity with the transmitter stalled
    for (int i = 0; i < 9; i++) do_write(32'h0, 32'(8'h60 + i), 4'h1, 0, 0, 0, 0);
    chk("d3_level", 32'(fifo_level), 8);
    // Push and pop in the same cycle while full: push dropped
    do_write(32'h0, 32'hEE, 4'h1, 0, 0, 0, 1);
    chk("d4_level", 32'(fifo_level), 7);
    do_pops(8);

    // Unmapped write with a slow B channel
    do_write(32'hC, 32'h5A, 4'hF, 0, 0, 5, 0);

    // Strobe 0 to TXDATA: no push
    do_write(32'h0, 32'h99, 4'hE, 0, 0, 0, 0);

    // Reset between AW and W discards the held address
    do_write(32'h8, 32'h1, 4'h1, 0, 0, 0, 0);
    do_write(32'h0, 32'h77, 4'h1, 0, 0, 0, 0);
    s_axi_awaddr = 32'h8; s_axi_awvalid = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    chk("d6_aw_held", 32'(s_axi_awready), 0);
    do_reset();
    chk_state("d6");
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'h1; s_axi_wvalid = 1'b1;
    tick();
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("d6_no_commit", 32'(s_axi_bvalid), 0);
    end
    chk("d6_txen", 32'(tx_en), 0);
    do_reset();

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: sel = 2'd0;
        3:       sel = 2'd1;
        4:       sel = 2'd2;
        default: sel = 2'd3;
      endcase
      a = $urandom;
      a[3:2] = sel;
      d = $urandom;
      do_write(a, d, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3),
               $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
      if ($urandom_range(0, 3) == 0) do_pops($urandom_range(0, 4));
    end
    do_pops(DEPTH + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
